// File: rtl/lif_neuron_array.sv
// -----------------------------------------------------------------------------
// lif_neuron_array
//
// Time-multiplexed leaky integrate-and-fire engine. NUM_NEURONS membrane
// voltages and last-update timestamps live in internal registers. One
// addressed synaptic event is accepted per cycle into stage S1. During the
// following cycle S1 reads the addressed neuron, applies leak, integrates the
// signed synaptic weight and decides whether to fire. At the next edge the
// state is written back and a firing neuron loads the spike output register.
//
// Optional feature (macro LIF_REFRACTORY_EN): each neuron also keeps a
// refractory counter that blocks integration and firing after a spike.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   clear_i               one-cycle pulse, wipes every neuron state to 0
//   rest_v_i, thr_v_i,
//   reset_v_i, leak_v_i   shared neuron configuration, used while in S1
//   refr_period_i         refractory reload value (optional feature only)
//   evt_*                 input event stream (valid/ready), op/addr/weight/
//                         scale/inhibitory flag/timestamp
//   spk_*                 output spike stream (valid/ready), addr/timestamp
// -----------------------------------------------------------------------------
module lif_neuron_array #(
    parameter int NUM_NEURONS      = 16,
    parameter int VOLTAGE_WIDTH    = 8,
    parameter int TIME_WIDTH       = 8,
    parameter int SYN_WEIGHT_WIDTH = 4,
    parameter int REFR_WIDTH       = 4,
    localparam int ADDR_WIDTH      = $clog2(NUM_NEURONS)
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        clear_i,
    input  logic [VOLTAGE_WIDTH-1:0]    rest_v_i,
    input  logic [VOLTAGE_WIDTH-1:0]    thr_v_i,
    input  logic [VOLTAGE_WIDTH-1:0]    reset_v_i,
    input  logic [VOLTAGE_WIDTH-1:0]    leak_v_i,
    input  logic [REFR_WIDTH-1:0]       refr_period_i,
    input  logic                        evt_valid_i,
    output logic                        evt_ready_o,
    input  logic [1:0]                  evt_op_i,
    input  logic [ADDR_WIDTH-1:0]       evt_addr_i,
    input  logic [SYN_WEIGHT_WIDTH-1:0] evt_weight_i,
    input  logic [SYN_WEIGHT_WIDTH-1:0] evt_scale_i,
    input  logic                        evt_inh_i,
    input  logic [TIME_WIDTH-1:0]       evt_time_i,
    output logic                        spk_valid_o,
    input  logic                        spk_ready_i,
    output logic [ADDR_WIDTH-1:0]       spk_addr_o,
    output logic [TIME_WIDTH-1:0]       spk_time_o
);

    localparam logic [1:0] OP_IDLE  = 2'b00;
    localparam logic [1:0] OP_SPIKE = 2'b01;
    localparam logic [1:0] OP_INTEG = 2'b10;
    localparam logic [1:0] OP_RST   = 2'b11;

    // Width that holds weight << scale for any scale, and at least one bit
    // more than the voltage so the overflow slice below is never empty.
    localparam int SHIFT_RAW   = SYN_WEIGHT_WIDTH + (1 << SYN_WEIGHT_WIDTH) - 1;
    localparam int SHIFT_WIDTH = (SHIFT_RAW > VOLTAGE_WIDTH) ? SHIFT_RAW : VOLTAGE_WIDTH + 1;
    localparam int PROD_WIDTH  = VOLTAGE_WIDTH + TIME_WIDTH;

    // Neuron state
    logic [VOLTAGE_WIDTH-1:0]    r_v  [NUM_NEURONS];
    logic [TIME_WIDTH-1:0]       r_ts [NUM_NEURONS];
`ifdef LIF_REFRACTORY_EN
    localparam int CMP_WIDTH = (TIME_WIDTH > REFR_WIDTH) ? TIME_WIDTH : REFR_WIDTH;
    logic [REFR_WIDTH-1:0]       r_refr [NUM_NEURONS];
    logic [REFR_WIDTH-1:0]       w_refr_cur;
    logic [REFR_WIDTH-1:0]       w_refr_dec;
    logic [REFR_WIDTH-1:0]       w_refr_wr;
`else
    logic                        w_unused_refr;
`endif

    // S1 stage registers
    logic                        r_s1_valid;
    logic [1:0]                  r_s1_op;
    logic [ADDR_WIDTH-1:0]       r_s1_addr;
    logic [SYN_WEIGHT_WIDTH-1:0] r_s1_weight;
    logic [SYN_WEIGHT_WIDTH-1:0] r_s1_scale;
    logic                        r_s1_inh;
    logic [TIME_WIDTH-1:0]       r_s1_time;

    // Spike output registers
    logic                        r_spk_valid;
    logic [ADDR_WIDTH-1:0]       r_spk_addr;
    logic [TIME_WIDTH-1:0]       r_spk_time;

    // Handshake and datapath wires
    logic                        w_s1_adv;
    logic                        w_s1_go;
    logic                        w_accept;
    logic [VOLTAGE_WIDTH-1:0]    w_v_cur;
    logic [TIME_WIDTH-1:0]       w_ts_cur;
    logic [TIME_WIDTH-1:0]       w_dt;
    logic [PROD_WIDTH-1:0]       w_leak_prod;
    logic [VOLTAGE_WIDTH-1:0]    w_leak_amt;
    logic [VOLTAGE_WIDTH-1:0]    w_v_leak;
    logic [SHIFT_WIDTH-1:0]      w_syn_wide;
    logic [VOLTAGE_WIDTH-1:0]    w_syn;
    logic [VOLTAGE_WIDTH:0]      w_sum;
    logic [VOLTAGE_WIDTH-1:0]    w_v_new;
    logic                        w_gated;
    logic                        w_fire;
    logic                        w_wr_en;
    logic [VOLTAGE_WIDTH-1:0]    w_v_wr;
    logic [TIME_WIDTH-1:0]       w_ts_wr;

    // S1 may only retire when the spike register can take a new spike.
    assign w_s1_adv    = ~r_spk_valid | spk_ready_i;
    assign w_s1_go     = r_s1_valid & w_s1_adv;
    assign evt_ready_o = ~r_s1_valid | w_s1_adv;
    assign w_accept    = evt_valid_i & evt_ready_o;

    assign spk_valid_o = r_spk_valid;
    assign spk_addr_o  = r_spk_addr;
    assign spk_time_o  = r_spk_time;

`ifndef LIF_REFRACTORY_EN
    assign w_unused_refr = ^refr_period_i;
`endif

    // Leak / integrate / fire datapath for the neuron addressed by S1
    always_comb begin
        w_v_cur     = r_v[r_s1_addr];
        w_ts_cur    = r_ts[r_s1_addr];
        w_dt        = r_s1_time - w_ts_cur;
        w_leak_prod = PROD_WIDTH'(leak_v_i) * PROD_WIDTH'(w_dt);
        w_leak_amt  = (|w_leak_prod[PROD_WIDTH-1:VOLTAGE_WIDTH]) ? {VOLTAGE_WIDTH{1'b1}}
                                                                 : w_leak_prod[VOLTAGE_WIDTH-1:0];
        w_gated     = 1'b0;

        // Leak towards rest without overshooting it
        if (w_v_cur > rest_v_i) begin
            if ((w_v_cur - rest_v_i) <= w_leak_amt) begin
                w_v_leak = rest_v_i;
            end else begin
                w_v_leak = w_v_cur - w_leak_amt;
            end
        end else if (w_v_cur < rest_v_i) begin
            if ((rest_v_i - w_v_cur) <= w_leak_amt) begin
                w_v_leak = rest_v_i;
            end else begin
                w_v_leak = w_v_cur + w_leak_amt;
            end
        end else begin
            w_v_leak = w_v_cur;
        end

`ifdef LIF_REFRACTORY_EN
        // Gating uses the counter after elapsed time has been taken off
        w_refr_cur = r_refr[r_s1_addr];
        if (CMP_WIDTH'(w_dt) >= CMP_WIDTH'(w_refr_cur)) begin
            w_refr_dec = {REFR_WIDTH{1'b0}};
        end else begin
            w_refr_dec = w_refr_cur - REFR_WIDTH'(w_dt);
        end
        w_gated = (w_refr_dec != {REFR_WIDTH{1'b0}});
`endif

        w_syn_wide = SHIFT_WIDTH'(r_s1_weight) << r_s1_scale;
        if (w_gated) begin
            w_syn = {VOLTAGE_WIDTH{1'b0}};
        end else if (|w_syn_wide[SHIFT_WIDTH-1:VOLTAGE_WIDTH]) begin
            w_syn = {VOLTAGE_WIDTH{1'b1}};
        end else begin
            w_syn = w_syn_wide[VOLTAGE_WIDTH-1:0];
        end

        w_sum = {1'b0, w_v_leak} + {1'b0, w_syn};
        if (r_s1_inh) begin
            if (w_syn > w_v_leak) begin
                w_v_new = {VOLTAGE_WIDTH{1'b0}};
            end else begin
                w_v_new = w_v_leak - w_syn;
            end
        end else if (w_sum[VOLTAGE_WIDTH]) begin
            w_v_new = {VOLTAGE_WIDTH{1'b1}};
        end else begin
            w_v_new = w_sum[VOLTAGE_WIDTH-1:0];
        end

        w_fire  = 1'b0;
        w_wr_en = 1'b0;
        w_v_wr  = w_v_cur;
        w_ts_wr = w_ts_cur;
        case (r_s1_op)
            OP_SPIKE: begin
                w_fire  = (w_v_new > thr_v_i) & ~w_gated;
                w_wr_en = 1'b1;
                w_v_wr  = w_fire ? reset_v_i : w_v_new;
                w_ts_wr = r_s1_time;
            end
            OP_INTEG: begin
                w_wr_en = 1'b1;
                w_v_wr  = w_v_new;
                w_ts_wr = r_s1_time;
            end
            OP_RST: begin
                w_wr_en = 1'b1;
                w_v_wr  = reset_v_i;
                w_ts_wr = {TIME_WIDTH{1'b0}};
            end
            OP_IDLE: begin
                w_wr_en = 1'b0;
            end
            default: begin
                w_wr_en = 1'b0;
            end
        endcase

`ifdef LIF_REFRACTORY_EN
        if (r_s1_op == OP_RST) begin
            w_refr_wr = {REFR_WIDTH{1'b0}};
        end else if (w_fire) begin
            w_refr_wr = refr_period_i;
        end else begin
            w_refr_wr = w_refr_dec;
        end
`endif
    end

    // Neuron state array: reset, bulk clear (wins over write-back), write-back
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            for (int i = 0; i < NUM_NEURONS; i++) begin
                r_v[i]    <= {VOLTAGE_WIDTH{1'b0}};
                r_ts[i]   <= {TIME_WIDTH{1'b0}};
`ifdef LIF_REFRACTORY_EN
                r_refr[i] <= {REFR_WIDTH{1'b0}};
`endif
            end
        end else if (w_s1_go && w_wr_en) begin
            r_v[r_s1_addr]    <= w_v_wr;
            r_ts[r_s1_addr]   <= w_ts_wr;
`ifdef LIF_REFRACTORY_EN
            r_refr[r_s1_addr] <= w_refr_wr;
`endif
        end
    end

    // S1 stage: load on accept, empty when it retires without a successor
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_s1_valid  <= 1'b0;
            r_s1_op     <= OP_IDLE;
            r_s1_addr   <= {ADDR_WIDTH{1'b0}};
            r_s1_weight <= {SYN_WEIGHT_WIDTH{1'b0}};
            r_s1_scale  <= {SYN_WEIGHT_WIDTH{1'b0}};
            r_s1_inh    <= 1'b0;
            r_s1_time   <= {TIME_WIDTH{1'b0}};
        end else if (w_accept) begin
            r_s1_valid  <= 1'b1;
            r_s1_op     <= evt_op_i;
            r_s1_addr   <= evt_addr_i;
            r_s1_weight <= evt_weight_i;
            r_s1_scale  <= evt_scale_i;
            r_s1_inh    <= evt_inh_i;
            r_s1_time   <= evt_time_i;
        end else if (w_s1_adv) begin
            r_s1_valid  <= 1'b0;
        end
    end

    // Spike register: reload on fire, otherwise drop after a handshake
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_spk_valid <= 1'b0;
            r_spk_addr  <= {ADDR_WIDTH{1'b0}};
            r_spk_time  <= {TIME_WIDTH{1'b0}};
        end else if (w_s1_go && w_fire) begin
            r_spk_valid <= 1'b1;
            r_spk_addr  <= r_s1_addr;
            r_spk_time  <= r_s1_time;
        end else if (spk_ready_i) begin
            r_spk_valid <= 1'b0;
        end
    end

endmodule

// File: doc/lif_neuron_array.md
Name: lif_neuron_array

Overview:
- Time-multiplexed, parametrised LIF engine holding NUM_NEURONS neuron states in internal registers.
- Processes one addressed synaptic event per cycle through a 2-stage valid/ready pipeline.
- Leaks, integrates signed (excitatory/inhibitory) weights and fires spike events onto an output stream with back-pressure.
- Sits between the event filter/decoder and the spike output arbiter of an SNE slice; replaces per-neuron combinational datapaths.

Parameters:
- NUM_NEURONS, 16, neurons held in the array; ADDR_WIDTH = $clog2(NUM_NEURONS) (localparam).
- VOLTAGE_WIDTH, 8, unsigned membrane voltage width.
- TIME_WIDTH, 8, timestamp width; deltas computed modulo 2^TIME_WIDTH.
- SYN_WEIGHT_WIDTH, 4, unsigned weight magnitude width; shift amount uses the same width.
- REFR_WIDTH, 4, refractory counter width (used only with the optional feature).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- clear_i  in  1  one-cycle pulse; wipes all neuron states to 0.
- rest_v_i / thr_v_i / reset_v_i / leak_v_i  in  VOLTAGE_WIDTH each  shared neuron config, sampled in S1.
- refr_period_i  in  REFR_WIDTH  refractory load value.
- evt_valid_i  in  1  input event valid.
- evt_ready_o  out  1  input event ready.
- evt_op_i  in  2  00 IDLE, 01 SPIKE (leak+integrate+fire), 10 INTEGRATE (leak+integrate, no fire), 11 RST.
- evt_addr_i  in  ADDR_WIDTH  target neuron.
- evt_weight_i  in  SYN_WEIGHT_WIDTH  weight magnitude.
- evt_scale_i  in  SYN_WEIGHT_WIDTH  left-shift applied to the weight.
- evt_inh_i  in  1  1 = inhibitory (subtract).
- evt_time_i  in  TIME_WIDTH  event timestamp.
- spk_valid_o  out  1  spike out valid.
- spk_ready_i  in  1  spike out ready.
- spk_addr_o  out  ADDR_WIDTH  firing neuron.
- spk_time_o  out  TIME_WIDTH  firing timestamp.

Behaviour:
- Reset: all neuron voltages and timestamps = 0; S1 empty; spk_valid_o = 0, spk_addr_o = 0, spk_time_o = 0. evt_ready_o = 1 from the first cycle after reset.
- Pipeline:
  - Accept at edge N when evt_valid_i & evt_ready_o; the event enters the S1 register.
  - During cycle N+1, S1 reads the addressed state and computes combinationally.
  - At edge N+2, S1 writes back the state; a firing event loads the spike register (spk_valid_o = 1 from N+2).
- Back-to-back events to the same address need no forwarding: write-back precedes the next S1 read. Both must be applied in order.
- Stall: s1_adv = ~spk_valid_o | spk_ready_i. evt_ready_o = ~s1_valid | s1_adv. S1 holds its event, with no write-back, while ~s1_adv.
- Spike register: holds addr/time stable while spk_valid_o & ~spk_ready_i. Clears on handshake unless reloaded the same edge.
- Arithmetic:
  - dt = evt_time - ts_stored, modulo 2^TIME_WIDTH.
  - leak_amt = leak_v * dt, saturated to VOLTAGE_WIDTH.
  - v above rest: v_l = max(v - leak_amt, rest). v below rest: v_l = min(v + leak_amt, rest). leak_v = 0 leaves v unchanged.
  - syn = weight << scale, saturated to all-ones.
  - Excitatory: v_n = v_l + syn, saturating at 2^VOLTAGE_WIDTH-1. Inhibitory: v_n = v_l - syn, saturating at 0.
  - SPIKE op fires iff v_n > thr_v (strict); stored voltage becomes reset_v.
  - INTEGRATE op never fires; stores v_n.
  - SPIKE and INTEGRATE both store ts = evt_time.
- IDLE op: consumes a slot; no state change, no spike.
- RST op: neuron voltage = reset_v, ts = 0, no spike.
- clear_i: all neurons set to 0 at the next edge. An S1 write-back in the same cycle is discarded; S1 and the spike register are unaffected.
- rst_i mid-operation: the in-flight S1 event and any pending spike are dropped.

Optional Feature:
- Macro: LIF_REFRACTORY_EN.
- With the macro: each neuron stores a REFR_WIDTH counter, reset/cleared to 0.
  - On fire, the counter loads refr_period_i.
  - On a SPIKE/INTEGRATE event with counter != 0: leak is applied and ts is updated; syn is forced to 0 and no fire occurs.
  - The counter decrements by dt, saturating at 0.
  - RST op zeroes the counter.
- Without the macro: no counter storage and no refractory gating.

Test Plan:
- Defaults, rest=0, thr=20, reset=0, leak=0: SPIKE events to addr 3 with weight 3, scale 2, t=1,2 -> v=12, then 24 > 20 fires. spk_addr_o=3, spk_time_o=2 at 2 cycles after the second accept; v(3)=0.
- leak=1, v(5)=10 at t=4; INTEGRATE at t=9 with weight 0 -> v(5)=5, no spike. Same at t=30 -> v(5)=0 (clamped at rest).
- Inhibitory weight 15, scale 3 on v=10 -> v=0 (saturates). Excitatory weight 15, scale 4 on v=200 -> v=255 and fires with thr=254.
- Hold spk_ready_i=0 after a spike: evt_ready_o drops to 0 while S1 is occupied; no event lost or duplicated. Releasing ready drains spikes in order.
- Back-to-back SPIKE events to addr 7 every cycle, weight 5, thr=12 -> fires on the 3rd event exactly, same result as spaced events. clear_i mid-stream -> all neurons 0.
- LIF_REFRACTORY_EN, refr_period=4: after a fire at t=10, events at t=11 and t=12 add nothing. Event at t=14 (counter 0) integrates normally.
